// File: rtl/dds_pkg.sv
// dds_pkg: waveform mode encoding and register address map for dds_multi
package dds_pkg;
  typedef enum logic [1:0] {SINE, SAW, TRI, SQUARE} mode_t;
  localparam logic [1:0] A_FTW  = 2'd0;
  localparam logic [1:0] A_OFF  = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_RSVD = 2'd3;
endpackage

// File: rtl/dds_sine_rom.sv
// dds_sine_rom: quarter-wave sine magnitude ROM, round(full_scale*sin), registered output
module dds_sine_rom #(
  parameter int AW = 6,
  parameter int DW = 7
) (
  input  logic          CLK,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  localparam int DEPTH = 1 << AW;
  typedef logic [DEPTH-1:0][DW-1:0] rom_t;
  function automatic rom_t gen_rom();
    rom_t r;
    for (int i = 0; i < DEPTH; i++)
      r[i] = DW'($rtoi(real'((1 << DW) - 1) * $sin(6.283185307179586 * i / (4.0 * DEPTH)) + 0.5));
    return r;
  endfunction
  localparam rom_t ROM = gen_rom();
  logic [DW-1:0] data_q, data_d;
  always_comb data_d = ROM[addr];
  always_ff @(posedge CLK) data_q <= data_d;
  assign data = data_q;
endmodule

// File: rtl/dds_multi.sv
// dds_multi: time-multiplexed multi-channel DDS (sine/saw/triangle/square), 3-cycle sample pipeline
// Define DDS_PHASE_DITHER_EN to add LFSR dither below the lookup truncation point.
module dds_multi
  import dds_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int PW    = 24,
  parameter int OW    = 8,
  parameter int LUTAW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          en,
  input  logic          wr_en,
  input  logic [3:0]    wr_ch,
  input  logic [1:0]    wr_addr,
  input  logic [PW-1:0] wr_data,
  output logic [OW-1:0] C,
  output logic          v,
  output logic [3:0]    ch
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int NS = 1 << CW;
  localparam int QW = LUTAW - 2;
  localparam logic [OW-1:0] HALF = OW'(1) << (OW - 1);
  localparam logic [OW-2:0] PEAK = '1;
  logic [PW-1:0] acc_q [NS], acc_d [NS];
  logic [PW-1:0] ftw_q [NS], ftw_d [NS];
  logic [PW-1:0] off_q [NS], off_d [NS];
  mode_t mode_q [NS], mode_d [NS];
  logic [CW-1:0] slot_q, slot_d, wi;
  logic v1_q, v1_d, v2_q, v2_d, v_q, v_d;
  logic [CW-1:0] ch1_q, ch1_d, ch2_q, ch2_d, ch_q, ch_d;
  mode_t mode1_q, mode1_d, mode2_q, mode2_d;
  logic [LUTAW-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [OW-1:0] c_q, c_d;
  logic [PW-1:0] next_acc, dith;
  logic [QW-1:0] rom_addr;
  logic [OW-2:0] rom_data, mag, tri_bits;
`ifdef DDS_PHASE_DITHER_EN
  localparam logic [PW-1:0] DMASK = {PW{1'b1}} >> LUTAW;
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge CLK) lfsr_q <= !RST_N ? 16'hACE1 : lfsr_d;
  assign dith = PW'(lfsr_q) & DMASK;
`else
  assign dith = '0;
`endif
  // Registers read here are pre-write, so a same-slot write lands on the channel's next slot.
  always_comb begin
    acc_d = acc_q;
    ftw_d = ftw_q;
    off_d = off_q;
    mode_d = mode_q;
    wi = wr_ch[CW-1:0];
    next_acc = acc_q[slot_q] + ftw_q[slot_q];
    slot_d = !en ? slot_q : slot_q == CW'(NCH - 1) ? '0 : slot_q + 1'b1;
    if (en) acc_d[slot_q] = next_acc;
    if (wr_en && 5'(wr_ch) < 5'(NCH)) begin
      ftw_d[wi] = wr_addr == A_FTW ? wr_data : ftw_q[wi];
      off_d[wi] = wr_addr == A_OFF ? wr_data : off_q[wi];
      mode_d[wi] = wr_addr == A_MODE ? mode_t'(wr_data[1:0]) : mode_q[wi];
    end
    v1_d = en;
    ch1_d = slot_q;
    mode1_d = mode_q[slot_q];
    p1_d = LUTAW'((next_acc + off_q[slot_q] + dith) >> (PW - LUTAW));
    v2_d = v1_q;
    ch2_d = ch1_q;
    mode2_d = mode1_q;
    p2_d = p1_q;
    rom_addr = p1_q[QW] ? QW'(~p1_q[QW-1:0] + 1'b1) : p1_q[QW-1:0];
    mag = p2_q[QW] && p2_q[QW-1:0] == '0 ? PEAK : rom_data;
    tri_bits = (OW - 1)'({p2_q[LUTAW-2:0], {(OW - 1){1'b0}}} >> (LUTAW - 1));
    c_d = mode2_q == SINE ? (p2_q[LUTAW-1] ? HALF - OW'(mag) : HALF + OW'(mag))
        : mode2_q == SAW  ? OW'({p2_q, {OW{1'b0}}} >> LUTAW)
        : mode2_q == TRI  ? {p2_q[LUTAW-1] ? ~tri_bits : tri_bits, 1'b0}
        : {OW{p2_q[LUTAW-1]}};
    v_d = v2_q;
    ch_d = ch2_q;
  end
  dds_sine_rom #(.AW(QW), .DW(OW - 1)) u_rom (
    .CLK (CLK),
    .addr(rom_addr),
    .data(rom_data)
  );
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_q <= '{default: '0};
      ftw_q <= '{default: '0};
      off_q <= '{default: '0};
      mode_q <= '{default: SINE};
      slot_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v_q <= 1'b0;
      ch1_q <= '0;
      ch2_q <= '0;
      ch_q <= '0;
      mode1_q <= SINE;
      mode2_q <= SINE;
      p1_q <= '0;
      p2_q <= '0;
      c_q <= '0;
    end else begin
      acc_q <= acc_d;
      ftw_q <= ftw_d;
      off_q <= off_d;
      mode_q <= mode_d;
      slot_q <= slot_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      v_q <= v_d;
      ch1_q <= ch1_d;
      ch2_q <= ch2_d;
      ch_q <= ch_d;
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      c_q <= c_d;
    end
  end
  assign C = c_q;
  assign v = v_q;
  assign ch = 4'(ch_q);
endmodule

// File: tb/tb_dds_multi.sv
// tb_dds_multi: randomized scoreboard bench for dds_multi against an arithmetic reference model
module tb_dds_multi;
  logic CLK = 1'b0, RST_N = 1'b0, en = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_ch = '0;
  logic [1:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [7:0] C;
  logic v;
  logic [3:0] ch;
  dds_multi dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .C(C), .v(v), .ch(ch)
  );
  always #5 CLK = ~CLK;
  typedef struct {int c; int ch; int due;} exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0, cnt = 0, slot = 0;
  logic [23:0] ph[2], ftw[2], off[2];
  int md[2];
  always @(posedge CLK) cnt <= cnt + 1;
  function automatic int ref_sample(input int m, input int p);
    real s;
    s = 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
    if (m == 0) return 128 + (s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5));
    if (m == 1) return p;
    if (m == 2) return 2 * (p >= 128 ? 255 - p : p);
    return p >= 128 ? 255 : 0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask
  task automatic cyc(input bit e, input bit we = 0, input int wc = 0, input int wa = 0, input logic [23:0] wd = 0);
    logic [23:0] lk;
    en = e; wr_en = we; wr_ch = 4'(wc); wr_addr = 2'(wa); wr_data = wd;
    if (e) begin
      ph[slot] = ph[slot] + ftw[slot];
      lk = ph[slot] + off[slot];
      sbq.push_back('{c: ref_sample(md[slot], int'(lk[23:16])), ch: slot, due: cnt + 3});
      slot = (slot + 1) % 2;
    end
    if (we && wc < 2 && wa != 3) begin
      if (wa == 0) ftw[wc] = wd;
      else if (wa == 1) off[wc] = wd;
      else md[wc] = int'(wd[1:0]);
    end
    @(posedge CLK); #1;
  endtask
  task automatic do_reset(input int n);
    RST_N = 1'b0; en = 1'b0; wr_en = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
    sbq.delete();
    for (int i = 0; i < 2; i++) begin ph[i] = '0; ftw[i] = '0; off[i] = '0; md[i] = 0; end
    slot = 0;
    @(negedge CLK);
    chk("reset_C", 32'(C), 32'h00);
    chk("reset_v", 32'(v), 32'h0);
    chk("reset_ch", 32'(ch), 32'h0);
    RST_N = 1'b1;
  endtask
  always @(negedge CLK) begin
    if (v === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_v got ch=%0d C=%02h at cycle %0d required no sample", ch, C, cnt);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (C !== e.c[7:0] || ch !== e.ch[3:0] || cnt != e.due) begin
          failures++;
          $display("FAIL sample got ch=%0d C=%02h cycle=%0d required ch=%0d C=%02h cycle=%0d",
                   ch, C, cnt, e.ch, e.c, e.due);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset(2);
    cyc(0, 1, 0, 2, 24'd1);
    cyc(0, 1, 0, 0, 24'h010000);
    repeat (600) cyc(1);
    do_reset(2);
    cyc(0, 1, 1, 2, 24'd3);
    cyc(0, 1, 1, 0, 24'h400000);
    cyc(0, 1, 0, 0, 24'h400000);
    repeat (24) cyc(1);
    do_reset(2);
    cyc(0, 1, 0, 1, 24'h800000);
    cyc(0, 1, 1, 2, 24'd1);
    cyc(0, 1, 1, 1, 24'h800000);
    repeat (12) cyc(1);
    cyc(1, 1, 2, 0, 24'h123456);
    cyc(1, 1, 2, 2, 24'd3);
    cyc(1, 1, 0, 3, 24'hFFFFFF);
    cyc(1, 1, 1, 0, 24'h030000);
    repeat (20) cyc(1);
    repeat (5) cyc(0);
    repeat (20) cyc(1);
    if (slot != 0) cyc(1);
    cyc(1, 1, 0, 0, 24'h050000);
    repeat (10) cyc(1);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3),
          $urandom_range(0, 3), 24'($urandom()));
    end
    repeat (6) cyc(0);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
